wb_frame_fetch: RTL
===================

Name: wb_frame_fetch

Overview:
- Wishbone classic read master sitting directly upstream of the Wishbone block-RAM slave in the frame-buffer path.
- Sweeps a frame of 32-bit pixel words from memory in raster order.
- Buffers the words in an internal FIFO and presents them as a valid/ready pixel stream to the display pipeline.
- Restarts at the frame base on a frame-sync pulse.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADR, 32'h0000_0000, byte address of pixel 0. Must be word-aligned.
- FIFO_DEPTH, 256, FIFO words. Must be a power of 2, ≥ 4.

Ports:
- wb_m.clk  input  1  single clock, carried in the wshb_if interface.
- wb_m.rst  input  1  synchronous, active-high reset, carried in the wshb_if interface.
- wb_m  wshb_if.master  -  cyc, stb, we, sel[3:0], adr[31:0], dat_ms[31:0] out; dat_sm[31:0], ack, err, rty in.
- frame_sync  input  1  one-cycle pulse: flush FIFO, restart at pixel 0.
- pix_data  output  32  head FIFO word.
- pix_valid  output  1  FIFO non-empty.
- pix_ready  input  1  consumer accepts pix_data this cycle.
- pix_sof  output  1  high while head word is pixel 0 of a frame.

Behaviour:
- Reset values: cyc=0, stb=0, we=0, sel=4'hF, adr=BASE_ADR, dat_ms=0, pix_valid=0, pix_sof=0, pixel index=0, FIFO empty.
- we, sel and dat_ms are constant: we=0, sel=4'hF, dat_ms=0.
- adr = BASE_ADR + 4*idx, where idx is the pixel index in [0, HDISP*VDISP-1]. Index width is $clog2(HDISP*VDISP).
- FSM states IDLE, REQ, DRAIN:
  - IDLE: cyc=stb=0. Go to REQ when the FIFO has at least 2 free slots.
  - REQ: cyc=stb=1, address held until ack.
  - On the ack cycle:
    - capture dat_sm into the FIFO, tagged with sof = (idx==0);
    - advance idx;
    - stay in REQ (stb stays high, adr steps to the next word in the same edge) if at least 2 slots will remain free, else go to IDLE.
  - Slave acks may arrive every other cycle; no minimum latency is assumed.
- Wrap-around: after idx = HDISP*VDISP-1 is acked, idx=0 and fetching continues into the next frame.
- err or rty while in REQ: treated as ack. The FIFO word is written as 0 so pixel alignment is kept.
- FIFO:
  - First-word-fall-through.
  - Push on ack; pop on pix_valid & pix_ready.
  - Simultaneous push/pop at full or empty is legal; count is unchanged.
  - Never pushes when full; the FSM margin guarantees this.
- frame_sync (highest priority after rst):
  - Next cycle: FIFO empty, idx=0, state=IDLE, cyc=stb=0.
  - An ack arriving in the same cycle as frame_sync is discarded.
  - Mid-transaction abort is allowed; the BRAM slave has no side effect on reads.
- pix_sof is valid only while pix_valid=1.
- rst mid-transaction: cyc/stb drop on the next edge; all state returns to reset values.
- Throughput with the BRAM slave: 1 word per 2 cycles.

Optional Feature:
- Macro: WB_FRAME_FETCH_UNDERRUN_EN.
- Defined:
  - Adds output underrun (1 bit), sticky. Set when pix_ready=1 and pix_valid=0 while the frame is running.
  - "Frame running" means: after the first pix_sof pop and before the next frame_sync.
  - Cleared by rst or frame_sync.
  - Adds output underrun_cnt[15:0], saturating, same increment and clear conditions.
- Undefined: ports absent, no added logic.

Decomposition:
- Package wb_frame_fetch_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
  - typedef struct packed {logic sof; logic [31:0] data;} fifo_word_t;
  - constant SEL_ALL = 4'hF.
- One sub-module: ff_fifo, parameterised on width and depth. It is a synchronous FWFT FIFO with full, empty and a count output. The FSM uses the count for its free-slot check.

Test Plan:
- BRAM preloaded mem[i]=i, HDISP=4, VDISP=2, pix_ready=1 → stream 0..7 then 0..7 again; pix_sof high on words 0 and 8; adr steps 0x0..0x1C then returns to 0x0.
- pix_ready=0 for 500 cycles, FIFO_DEPTH=8 → at most 7 words fetched, cyc=0 after that, no FIFO overflow; release → in-order 0,1,2…
- frame_sync pulsed while stb=1 on idx=5 (ack arriving the same cycle) → word 5 dropped; next cycle pix_valid=0, then adr=BASE_ADR; the first output word is 0 with sof=1.
- err asserted on idx=3 → output sequence 0,1,2,0,4,… with no stall.
- rst asserted for 1 cycle mid-transfer → cyc=stb=0, pix_valid=0 next cycle; restart from idx 0.
- (UNDERRUN_EN) pix_ready=1 with the slave stalled 20 cycles after the first sof → underrun=1, underrun_cnt=20; frame_sync clears both to 0.

Source files
------------

// File: rtl/wb_frame_fetch_pkg.sv
// Shared types and constants for the frame-fetch Wishbone read master.
// Used by wb_frame_fetch and its testbench.
package wb_frame_fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } fifo_word_t;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Byte address of a pixel word given the frame base and pixel index.
  function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle; clk and rst travel with the bus.
// dat_ms is master-to-slave data, dat_sm is slave-to-master data.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output cyc, stb, we, sel, adr, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, dat_ms,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/ff_fifo.sv
// Synchronous first-word-fall-through FIFO: dout shows the head word whenever
// empty is low. DEPTH must be a power of two; flush empties it in one cycle.
module ff_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             wr_en;
  logic             rd_en;

  // At full, a simultaneous pop frees the slot the write lands in.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/wb_frame_fetch.sv
// Raster-order Wishbone read master feeding a FWFT pixel FIFO.
// Optional macro WB_FRAME_FETCH_UNDERRUN_EN adds underrun / underrun_cnt outputs.
module wb_frame_fetch
  import wb_frame_fetch_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 256
) (
  wshb_if.master       wb_m,
  input  logic         frame_sync,
  output logic [31:0]  pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_sof,
`ifdef WB_FRAME_FETCH_UNDERRUN_EN
  output logic         underrun,
  output logic [15:0]  underrun_cnt,
`endif
  output fetch_state_t dbg_state
);

  localparam int NPIX  = HDISP * VDISP;
  localparam int IDX_W = $clog2(NPIX);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    FILL_LIMIT = CW'(FIFO_DEPTH - 2);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NPIX - 1);

  fetch_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             cyc_r;
  logic             stb_r;
  logic [31:0]      adr_r;

  fifo_word_t       push_word;
  fifo_word_t       head;
  logic             bus_done;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_after;
  logic             start_ok;
  logic             stay_ok;

  // Pixel stream handshake: a word transfers on every cycle where pix_valid
  // and pix_ready are both high; pix_data/pix_sof hold until that happens.
  assign pop       = pix_valid && pix_ready;
  assign pix_valid = !fifo_empty;
  assign pix_data  = head.data;
  assign pix_sof   = pix_valid && head.sof;

  // err/rty complete the beat like ack so the raster position never slips.
  assign bus_done = (state == REQ) && (wb_m.ack || wb_m.err || wb_m.rty);
  assign push     = bus_done && !frame_sync && !(fifo_full && !pop);
  assign idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);

  always_comb begin
    push_word      = '0;
    push_word.sof  = (idx == '0);
    push_word.data = (wb_m.err || wb_m.rty) ? 32'h0 : wb_m.dat_sm;
  end

  // Two free slots of margin are kept so a beat in flight always has room.
  assign count_after = pop ? fifo_count : fifo_count + CW'(1);
  assign start_ok    = (fifo_count <= FILL_LIMIT);
  assign stay_ok     = (count_after <= FILL_LIMIT);

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst || frame_sync) begin
      state <= IDLE;
      cyc_r <= 1'b0;
      stb_r <= 1'b0;
      adr_r <= BASE_ADR;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= REQ;
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
          end
        end
        REQ: begin
          if (bus_done) begin
            idx   <= idx_next;
            adr_r <= word_adr(BASE_ADR, 32'(idx_next));
            if (!stay_ok) begin
              state <= IDLE;
              cyc_r <= 1'b0;
              stb_r <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cyc_r <= 1'b0;
          stb_r <= 1'b0;
        end
      endcase
    end
  end

  assign wb_m.cyc    = cyc_r;
  assign wb_m.stb    = stb_r;
  assign wb_m.adr    = adr_r;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = SEL_ALL;
  assign wb_m.dat_ms = 32'h0;
  assign dbg_state   = state;

  ff_fifo #(
    .WIDTH($bits(fifo_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (wb_m.clk),
    .rst  (wb_m.rst),
    .flush(frame_sync),
    .push (push),
    .din  (push_word),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

`ifdef WB_FRAME_FETCH_UNDERRUN_EN
  logic running;

  // The frame counts as running once its first pixel has been consumed.
  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst || frame_sync) begin
      running      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (pop && head.sof) running <= 1'b1;
      if (running && pix_ready && !pix_valid) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
